// File: rtl/mul_pkg.sv
// mul_pkg: shared widths, operand/product types and the controller state encoding
package mul_pkg;
   localparam int MUL_WIDTH = 16;
   typedef logic [MUL_WIDTH-1:0] operand_t;
   typedef logic [2*MUL_WIDTH-1:0] product_t;
   typedef enum logic [1:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_DEC} State;
endpackage

// File: rtl/mul_datapath_if.sv
// mul_datapath_if: operand/control bus from controlpath plus the product valid/ready slice
interface mul_datapath_if import mul_pkg::*; #(parameter int WIDTH = MUL_WIDTH);
   logic [WIDTH-1:0] data_in;
   logic loadA, loadB, decB, zero;
   logic [2*WIDTH-1:0] res_data;
   logic res_valid, res_ready, overrun;
   modport master(output data_in, loadA, loadB, decB, res_ready, input zero, res_data, res_valid, overrun);
   modport slave(input data_in, loadA, loadB, decB, res_ready, output zero, res_data, res_valid, overrun);
endinterface

// File: rtl/mul_down_counter.sv
// mul_down_counter: loadable counter that decrements only while non-zero, so it never wraps
module mul_down_counter #(parameter int WIDTH = 16) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic is_zero
);
   assign is_zero = q == '0;
   always_ff @(posedge clk)
      if (rst) q <= '0;
      else if (load) q <= d;
      else if (dec && !is_zero) q <= q - 1'b1;
endmodule

// File: rtl/mul_datapath.sv
// mul_datapath: repeat-add multiplier datapath (A, B counter, accumulator P) with a one-deep product slice
module mul_datapath import mul_pkg::*; #(parameter int WIDTH = MUL_WIDTH) (
   input logic clk,
   input logic rst,
   mul_datapath_if.slave bus
);
   logic [WIDTH-1:0] a, b;
   logic [2*WIDTH-1:0] p, res;
   logic captured, valid, ovr, zero, iter, cap, free;
   assign iter = bus.decB && !bus.loadA && !bus.loadB;
   assign cap = iter && zero && !captured;
   assign free = !valid || bus.res_ready;
   assign bus.zero = zero;
   assign bus.res_data = res;
   assign bus.res_valid = valid;
   assign bus.overrun = ovr;
   mul_down_counter #(.WIDTH(WIDTH)) u_b (
      .clk(clk), .rst(rst), .load(bus.loadB), .dec(iter), .d(bus.data_in), .q(b), .is_zero(zero)
   );
   always_ff @(posedge clk)
      if (rst) begin
         a <= '0;
         p <= '0;
         res <= '0;
         captured <= 1'b0;
         valid <= 1'b0;
         ovr <= 1'b0;
      end else begin
         if (bus.loadA) begin
            a <= bus.data_in;
            p <= '0;
            captured <= 1'b0;
         end else begin
            if (iter && !zero) p <= p + {{WIDTH{1'b0}}, a};
            if (cap) captured <= 1'b1;
         end
         // a capture into a free slot wins over the handshake clearing valid
         if (cap && free) begin
            res <= p;
            valid <= 1'b1;
         end else if (valid && bus.res_ready) valid <= 1'b0;
         if (cap && !free) ovr <= 1'b1;
      end
endmodule

// File: tb/tb_mul_datapath.sv
// tb_mul_datapath: directed and randomized operations checked against plain a*b arithmetic
module tb_mul_datapath;
   import mul_pkg::*;
   logic clk = 1'b0;
   logic rst;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   mul_datapath_if #(.WIDTH(MUL_WIDTH)) bus();
   mul_datapath #(.WIDTH(MUL_WIDTH)) dut(.clk(clk), .rst(rst), .bus(bus));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // load A then B, then iterate B times leaving decB high; the next edge is the capture
   task automatic do_op(operand_t a, operand_t b);
      bus.decB = 1'b0;
      bus.loadA = 1'b1;
      bus.data_in = a;
      tick();
      bus.loadA = 1'b0;
      bus.loadB = 1'b1;
      bus.data_in = b;
      tick();
      bus.loadB = 1'b0;
      chk("zero_after_load", 64'(bus.zero), 64'(b == 0));
      bus.decB = 1'b1;
      for (int i = 1; i <= int'(b); i++) begin
         tick();
         if (b <= 32) chk("zero_count", 64'(bus.zero), 64'(i == int'(b)));
      end
      chk("zero_done", 64'(bus.zero), 64'd1);
   endtask

   initial begin
      operand_t ra, rb, ra2, rb2;
      product_t p1, p2;
      rst = 1'b1;
      bus.data_in = '0;
      bus.loadA = 1'b0;
      bus.loadB = 1'b0;
      bus.decB = 1'b0;
      bus.res_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("rst_zero", 64'(bus.zero), 64'd1);
      chk("rst_valid", 64'(bus.res_valid), 64'd0);
      chk("rst_overrun", 64'(bus.overrun), 64'd0);
      chk("rst_data", 64'(bus.res_data), 64'd0);

      bus.res_ready = 1'b1;
      do_op(16'd7, 16'd5);
      tick();
      chk("7x5_valid", 64'(bus.res_valid), 64'd1);
      chk("7x5_data", 64'(bus.res_data), 64'd35);
      tick();
      chk("7x5_pulse", 64'(bus.res_valid), 64'd0);

      do_op(16'hFFFF, 16'hFFFF);
      tick();
      chk("max_valid", 64'(bus.res_valid), 64'd1);
      chk("max_data", 64'(bus.res_data), 64'hFFFE0001);
      tick();
      chk("max_pulse", 64'(bus.res_valid), 64'd0);

      do_op(16'd1234, 16'd0);
      tick();
      chk("b0_valid", 64'(bus.res_valid), 64'd1);
      chk("b0_data", 64'(bus.res_data), 64'd0);
      tick();
      chk("b0_once", 64'(bus.res_valid), 64'd0);
      tick();
      chk("b0_still", 64'(bus.res_valid), 64'd0);
      chk("b0_nowrap", 64'(bus.zero), 64'd1);

      do_op(16'd0, 16'd9);
      tick();
      chk("a0_data", 64'(bus.res_data), 64'd0);
      chk("a0_valid", 64'(bus.res_valid), 64'd1);
      tick();

      for (int n = 0; n < 6; n++) begin
         ra = operand_t'($urandom);
         rb = operand_t'($urandom_range(0, 12));
         do_op(ra, rb);
         tick();
         chk("rand_valid", 64'(bus.res_valid), 64'd1);
         chk("rand_data", 64'(bus.res_data), 64'(product_t'(ra) * product_t'(rb)));
         tick();
         chk("rand_pulse", 64'(bus.res_valid), 64'd0);
      end

      bus.res_ready = 1'b0;
      ra = operand_t'($urandom);
      rb = operand_t'($urandom_range(1, 10));
      p1 = product_t'(ra) * product_t'(rb);
      do_op(ra, rb);
      tick();
      chk("hold_valid", 64'(bus.res_valid), 64'd1);
      chk("hold_data", 64'(bus.res_data), 64'(p1));
      chk("hold_no_ovr", 64'(bus.overrun), 64'd0);
      do_op(16'd3, 16'd4);
      tick();
      chk("ovr_set", 64'(bus.overrun), 64'd1);
      chk("ovr_keep_data", 64'(bus.res_data), 64'(p1));
      chk("ovr_keep_valid", 64'(bus.res_valid), 64'd1);
      bus.res_ready = 1'b1;
      tick();
      chk("ovr_drained", 64'(bus.res_valid), 64'd0);
      chk("ovr_sticky", 64'(bus.overrun), 64'd1);

      bus.res_ready = 1'b0;
      ra = operand_t'($urandom);
      rb = operand_t'($urandom_range(1, 8));
      ra2 = operand_t'($urandom);
      rb2 = operand_t'($urandom_range(1, 8));
      p1 = product_t'(ra) * product_t'(rb);
      p2 = product_t'(ra2) * product_t'(rb2);
      do_op(ra, rb);
      tick();
      chk("b2b_first", 64'(bus.res_data), 64'(p1));
      do_op(ra2, rb2);
      bus.res_ready = 1'b1;
      tick();
      chk("b2b_valid", 64'(bus.res_valid), 64'd1);
      chk("b2b_second", 64'(bus.res_data), 64'(p2));
      tick();
      chk("b2b_drained", 64'(bus.res_valid), 64'd0);

      bus.res_ready = 1'b0;
      do_op(16'd5, 16'd2);
      tick();
      chk("pre_rst_valid", 64'(bus.res_valid), 64'd1);
      bus.decB = 1'b0;
      bus.loadA = 1'b1;
      bus.data_in = 16'd9;
      tick();
      bus.loadA = 1'b0;
      bus.loadB = 1'b1;
      bus.data_in = 16'd4;
      tick();
      bus.loadB = 1'b0;
      bus.decB = 1'b1;
      tick();
      tick();
      chk("mid_zero", 64'(bus.zero), 64'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.decB = 1'b0;
      chk("mrst_zero", 64'(bus.zero), 64'd1);
      chk("mrst_valid", 64'(bus.res_valid), 64'd0);
      chk("mrst_data", 64'(bus.res_data), 64'd0);
      chk("mrst_overrun", 64'(bus.overrun), 64'd0);
      tick();
      tick();
      chk("mrst_no_cap", 64'(bus.res_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mul_datapath.md
# mul_datapath

Datapath for the sequential repeat-add multiplier, directly downstream of `controlpath`. It consumes `loadA`, `loadB` and `decB` and feeds `zero` back to `controlpath`. It holds multiplicand A, the down-counting multiplier B and the accumulator P. On completion it hands the 2·WIDTH-bit product to the next stage through a valid/ready register slice.

## Interface
- `WIDTH`, 16, operand width in bits; must be ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `data_in`  in  WIDTH  shared operand bus; sampled on `loadA` and on `loadB`.
- `loadA`  in  1  load A from `data_in` and clear P.
- `loadB`  in  1  load B from `data_in`.
- `decB`  in  1  one iteration: P += A and B -= 1, when B ≠ 0.
- `zero`  out  1  combinational `B == 0`; goes to `controlpath`.
- `res_data`  out  2·WIDTH  registered product.
- `res_valid`  out  1  `res_data` holds an unconsumed product.
- `res_ready`  in  1  downstream accepts the product.
- `overrun`  out  1  sticky; set when a product is dropped.

## Operation
- All registers are updated on the rising edge of `clk`.
- **Reset:** A, B, P, `res_data`, `res_valid`, `overrun` and the internal `captured` flag all go to 0. As a result `zero` = 1 out of reset.
- **`loadA`:** A ← `data_in`, P ← 0, `captured` ← 0.
- **`loadB`:** B ← `data_in`. `loadA` and `loadB` are independent and may both fire in the same cycle.
- **`decB` with B ≠ 0:** P ← P + A, computed at 2·WIDTH bits with A zero-extended; no overflow is possible. B ← B − 1.
- **`decB` with B = 0:** B and P hold; B never wraps.
- **Precedence:** `decB` is ignored in any cycle where `loadA` or `loadB` is asserted.
- **Capture:**
  - Triggered when `decB` && `zero` && !`captured`.
  - If the slice is free (`res_valid` == 0, or `res_ready` == 1 in the same cycle): `res_data` ← P and `res_valid` ← 1.
  - Otherwise the product is dropped and `overrun` ← 1.
  - In both cases `captured` ← 1, so a controller dwelling in its decrement state captures only once.
- **Handshake:** a transfer occurs on a cycle where `res_valid` && `res_ready`. `res_valid` falls on the following edge unless a new capture happens in the same cycle, in which case `res_valid` stays 1 and `res_data` takes the new P. `res_data` is stable while `res_valid` is high and `res_ready` is low.
- **Zero operands:** B = 0 at the first `decB` captures P = 0. A = 0 iterates B times and yields 0.
- **Reset mid-operation:** clears everything, including a pending `res_valid`; the product is lost and `overrun` is not set.

## Timing
- `zero` is combinational from the B register, valid in the cycle after the edge that updates B.
- Product latency: loadA/loadB edge, then B `decB` edges, then the capture edge. `res_valid` is high at edge B+1 after the last load.
- The result slice adds one register stage. There is no combinational path from `res_ready` to `res_valid` or `res_data`.
- Back-to-back operations are supported. A new `loadA` clears P and `captured` but leaves the output slice untouched.

## Structure
- Package `mul_pkg` holds:
  - `localparam MUL_WIDTH = 16`;
  - `typedef logic [MUL_WIDTH-1:0] operand_t`;
  - `typedef logic [2*MUL_WIDTH-1:0] product_t`;
  - the `State` enum, moved here from `controlpath` so both sides share it.
- Sub-module `mul_down_counter` (WIDTH parameter): load, decrement-if-nonzero, `is_zero` output. It implements B.
- A, P, the adder and the result slice stay inline in `mul_datapath`.

## Test plan
- `rst`, then idle → `zero` = 1, `res_valid` = 0, `overrun` = 0, `res_data` = 0.
- `loadA` with 7, `loadB` with 5, `decB` held with `res_ready` = 1 → B counts 5→0 over 5 edges; `res_data` = 35 with `res_valid` pulsing once.
- A = 0xFFFF, B = 0xFFFF, WIDTH = 16 → `res_data` = 0xFFFE0001, no truncation.
- B = 0 then `decB` for 3 cycles → a single capture of 0; `captured` blocks repeats and B does not wrap.
- `res_ready` = 0 with a product pending, then a second operation (3×4) completes → first product held, `overrun` = 1. Raising `res_ready` transfers the first product; the second is dropped.
- `rst` asserted while B = 2 during decrementing → next cycle all registers are 0 and `zero` = 1; no capture follows.
